program_counter_unit: RTL and testbench

PROGRAM_COUNTER_UNIT -- requirements
Module: program_counter_unit

---
 rtl/program_counter_unit.sv | 119 +++++++++++
 tb/tb_program_counter_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/program_counter_unit.sv
// Fetch-stage program counter: BOOT/RUN/PEND sequencing, Jr > Jump > Branch redirect
// priority, and a pending-target register for redirects that arrive while fetch is held.
module program_counter_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Jump,
  input  logic [31:0] Jump_Ext,
  input  logic        Branch,
  input  logic [31:0] Branch_Ext,
  input  logic        Jr,
  input  logic [31:0] Jr_Target,
  input  logic        Fetch_Ready,
  output logic [31:0] PC,
  output logic [31:0] PC_Plus4,
  output logic        Fetch_Valid,
  output logic        Flush
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pending_reg, pending_next;
  logic        flush_reg, flush_next;

  logic        accept;
  logic        redirect;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] jr_target_aligned;
  logic [31:0] redirect_target;

  // Bits dropped by the target arithmetic; folded here so they are visibly consumed.
  logic unused_bits;
  assign unused_bits = ^{Jump_Ext[31:26], Branch_Ext[31:30], Jr_Target[1:0]};

  assign PC_Plus4 = pc_reg + 32'd4;
  assign accept   = Fetch_Ready & ~Stall;
  assign redirect = Jr | Jump | Branch;

  assign jump_target       = {PC_Plus4[31:28], Jump_Ext[25:0], 2'b00};
  assign branch_target     = PC_Plus4 + {Branch_Ext[29:0], 2'b00};
  assign jr_target_aligned = {Jr_Target[31:2], 2'b00};

  always_comb begin
    redirect_target = branch_target;
    if (Jr) begin
      redirect_target = jr_target_aligned;
    end else if (Jump) begin
      redirect_target = jump_target;
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= BOOT;
      pc_reg      <= RESET_VECTOR;
      pending_reg <= 32'h0000_0000;
      flush_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      pending_reg <= pending_next;
      flush_reg   <= flush_next;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    pending_next = pending_reg;
    flush_next   = 1'b0;
    case (state_reg)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        if (accept) begin
          pc_next    = redirect ? redirect_target : PC_Plus4;
          flush_next = redirect;
        end else if (redirect) begin
          pending_next = redirect_target;
          state_next   = PEND;
        end
      end
      PEND: begin
        // A request arriving on the accepting cycle is the newest overwrite, so it wins.
        if (redirect) begin
          pending_next = redirect_target;
        end
        if (accept) begin
          pc_next    = redirect ? redirect_target : pending_reg;
          flush_next = 1'b1;
          state_next = RUN;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    Fetch_Valid = (state_reg == RUN) || (state_reg == PEND);
    Flush       = flush_reg;
    PC          = pc_reg;
  end

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench for program_counter_unit: the driver queues the expected post-edge
// state of each cycle and a monitor pops and compares after every rising edge.
module tb_program_counter_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        Jump;
  logic [31:0] Jump_Ext;
  logic        Branch;
  logic [31:0] Branch_Ext;
  logic        Jr;
  logic [31:0] Jr_Target;
  logic        Fetch_Ready;
  logic [31:0] PC;
  logic [31:0] PC_Plus4;
  logic        Fetch_Valid;
  logic        Flush;

  typedef struct packed {
    logic [31:0] pc;
    logic        flush;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  program_counter_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .Stall      (Stall),
    .Jump       (Jump),
    .Jump_Ext   (Jump_Ext),
    .Branch     (Branch),
    .Branch_Ext (Branch_Ext),
    .Jr         (Jr),
    .Jr_Target  (Jr_Target),
    .Fetch_Ready(Fetch_Ready),
    .PC         (PC),
    .PC_Plus4   (PC_Plus4),
    .Fetch_Valid(Fetch_Valid),
    .Flush      (Flush)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL txn %0d %s: got %h, expected %h", txn, name, act, req);
    end
  endfunction

  // Drive one cycle of inputs (just after a falling edge) and queue the state expected after the next rising edge.
  task automatic step(input logic rst, input logic st, input logic fr,
                      input logic jr, input logic jp, input logic br,
                      input logic [31:0] jr_t, input logic [31:0] jext, input logic [31:0] bext,
                      input logic [31:0] epc, input logic efl, input logic eva);
    exp_t e;
    reset       = rst;
    Stall       = st;
    Fetch_Ready = fr;
    Jr          = jr;
    Jump        = jp;
    Branch      = br;
    Jr_Target   = jr_t;
    Jump_Ext    = jext;
    Branch_Ext  = bext;
    e.pc    = epc;
    e.flush = efl;
    e.valid = eva;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one comparison record per rising edge whenever an expectation is queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d: PC=%h PC_Plus4=%h Fetch_Valid=%b Flush=%b", txn, PC, PC_Plus4, Fetch_Valid, Flush);
        check("PC", PC, e.pc);
        check("PC_Plus4", PC_Plus4, e.pc + 32'd4);
        check("Fetch_Valid", {31'd0, Fetch_Valid}, {31'd0, e.valid});
        check("Flush", {31'd0, Flush}, {31'd0, e.flush});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; Stall = 1'b0; Fetch_Ready = 1'b1;
    Jr = 1'b0; Jump = 1'b0; Branch = 1'b0;
    Jr_Target = 32'h0; Jump_Ext = 32'h0; Branch_Ext = 32'h0;
    @(negedge clk);
    //    rst st fr jr jp br  Jr_Target      Jump_Ext       Branch_Ext      exp PC        fl va
    step(0, 0, 1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0000_0000, 0, 0);
    step(0, 0, 1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0000_0000, 0, 0);
    // Release: BOOT -> RUN first, then sequential fetch
    step(1, 0, 1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0000_0000, 0, 1);
    step(1, 0, 1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0000_0004, 0, 1);
    step(1, 0, 1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0000_0008, 0, 1);
    step(1, 0, 1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0000_000C, 0, 1);
    // Jump with negative 26-bit field
    step(1, 0, 1, 1, 0, 0, 32'h0040_0013,  32'h0,         32'h0,         32'h0040_0010, 1, 1);
    step(1, 0, 1, 0, 1, 0, 32'h0,          32'hFFFF_FFFE, 32'h0,         32'h0FFF_FFF8, 1, 1);
    step(1, 0, 1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0FFF_FFFC, 0, 1);
    // Branch offsets -1 and +2 words
    step(1, 0, 1, 1, 0, 0, 32'h0000_0100,  32'h0,         32'h0,         32'h0000_0100, 1, 1);
    step(1, 0, 1, 0, 0, 1, 32'h0,          32'h0,         32'hFFFF_FFFF, 32'h0000_0100, 1, 1);
    step(1, 0, 1, 0, 0, 1, 32'h0,          32'h0,         32'h0000_0002, 32'h0000_010C, 1, 1);
    // Jump under stall goes to PEND, applied on release
    step(1, 0, 1, 1, 0, 0, 32'h0000_0020,  32'h0,         32'h0,         32'h0000_0020, 1, 1);
    step(1, 1, 1, 0, 1, 0, 32'h0,          32'h0000_0006, 32'h0,         32'h0000_0020, 0, 1);
    step(1, 1, 1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0000_0020, 0, 1);
    step(1, 0, 1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0000_0018, 1, 1);
    step(1, 0, 1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0000_001C, 0, 1);
    // Holds: Fetch_Ready low, then both hold conditions together
    step(1, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0000_001C, 0, 1);
    step(1, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0000_001C, 0, 1);
    // Pending target overwritten by a later Jr before acceptance
    step(1, 0, 0, 0, 0, 1, 32'h0,          32'h0,         32'h0000_0004, 32'h0000_001C, 0, 1);
    step(1, 0, 0, 1, 0, 0, 32'h0000_0204,  32'h0,         32'h0,         32'h0000_001C, 0, 1);
    step(1, 0, 1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0000_0204, 1, 1);
    // Priority: Jr > Jump > Branch
    step(1, 0, 1, 1, 1, 1, 32'h0000_0083,  32'h0000_0005, 32'h0000_0003, 32'h0000_0080, 1, 1);
    step(1, 0, 1, 0, 1, 1, 32'h0,          32'h0000_0040, 32'h0000_0001, 32'h0000_0100, 1, 1);
    // Jump_Ext[31:26] ignored; upper nibble comes from PC_Plus4
    step(1, 0, 1, 0, 1, 0, 32'h0,          32'hFC00_0010, 32'h0,         32'h0000_0040, 1, 1);
    step(1, 0, 1, 1, 0, 0, 32'hA000_0000,  32'h0,         32'h0,         32'hA000_0000, 1, 1);
    step(1, 0, 1, 0, 1, 0, 32'h0,          32'h0000_0010, 32'h0,         32'hA000_0040, 1, 1);
    // Sequential and branch wrap-around
    step(1, 0, 1, 1, 0, 0, 32'hFFFF_FFFF,  32'h0,         32'h0,         32'hFFFF_FFFC, 1, 1);
    step(1, 0, 1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0000_0000, 0, 1);
    step(1, 0, 1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0000_0004, 0, 1);
    step(1, 0, 1, 1, 0, 0, 32'hFFFF_FFF0,  32'h0,         32'h0,         32'hFFFF_FFF0, 1, 1);
    step(1, 0, 1, 0, 0, 1, 32'h0,          32'h0,         32'h0000_0004, 32'h0000_0004, 1, 1);
    // Reset during PEND discards the pending redirect
    step(1, 1, 1, 0, 1, 0, 32'h0,          32'h0000_0010, 32'h0,         32'h0000_0004, 0, 1);
    step(0, 0, 1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0000_0000, 0, 0);
    step(1, 0, 1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0000_0000, 0, 1);
    step(1, 0, 1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0000_0004, 0, 1);

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
